// File: rtl/card_dealer.sv
// card_dealer: deals blackjack cards from an LFSR into a hand of MAX_CARDS slots.
// The FSM retries in DRAW until it finds a valid, unused code, then records
// that card in COMMIT. The 64-bit used bitmap prevents duplicates within a game.
module card_dealer #(
    parameter int          MAX_CARDS = 9,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   new_game,
    input  logic                   deal_req,
    input  logic                   force_en,
    input  logic [5:0]             force_code,
    output logic                   deal_ack,
    output logic [MAX_CARDS*6-1:0] slot_code,
    output logic [MAX_CARDS-1:0]   slot_valid,
    output logic [3:0]             card_count,
    output logic [4:0]             hand_value,
    output logic                   busy,
    output logic                   hand_full,
    output logic                   bust
);

    typedef enum logic [1:0] {IDLE, DRAW, COMMIT} state_t;

    state_t      state, state_next;
    logic [15:0] lfsr;
    logic [63:0] used;
    logic [5:0]  cand, held;
    logic        accept;
    logic [5:0]  sum, card_val, sum_next;
    logic [3:0]  soft_aces, aces_next;
    logic [3:0]  rank;

    // Free-running random source; new_game intentionally leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign cand   = force_en ? force_code : lfsr[5:0];
    assign accept = (cand[3:0] <= 4'd12) && !used[cand];

    assign busy       = (state != IDLE);
    assign hand_value = sum[4:0];
    assign bust       = (hand_value > 5'd21);
    assign hand_full  = (card_count == 4'(MAX_CARDS));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; new_game overrides everything.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (deal_req && !hand_full && !bust) state_next = DRAW;
            DRAW:    if (accept) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (new_game) state_next = IDLE;
    end

    // Score update for the held card: Ace counts 11 and is demoted to 1 at most
    // once per card if the hand would otherwise bust.
    always_comb begin
        rank     = held[3:0];
        card_val = {2'b00, rank} + 6'd1;
        if (rank == 4'd0)        card_val = 6'd11;
        else if (rank >= 4'd10)  card_val = 6'd10;
        sum_next  = sum + card_val;
        aces_next = soft_aces + {3'b000, (rank == 4'd0)};
        if ((sum_next > 6'd21) && (aces_next != 4'd0)) begin
            sum_next  = sum_next - 6'd10;
            aces_next = aces_next - 4'd1;
        end
    end

    // Hand, deck and score registers; a commit is dropped if new_game lands on it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            used       <= '0;
            held       <= '0;
            slot_code  <= '0;
            slot_valid <= '0;
            card_count <= '0;
            sum        <= '0;
            soft_aces  <= '0;
            deal_ack   <= 1'b0;
        end else if (new_game) begin
            used       <= '0;
            held       <= '0;
            slot_code  <= '0;
            slot_valid <= '0;
            card_count <= '0;
            sum        <= '0;
            soft_aces  <= '0;
            deal_ack   <= 1'b0;
        end else begin
            deal_ack <= 1'b0;
            if (state == DRAW && accept) held <= cand;
            if (state == COMMIT) begin
                for (int i = 0; i < MAX_CARDS; i++) begin
                    if (card_count == 4'(i)) begin
                        slot_code[i*6 +: 6] <= held;
                        slot_valid[i]       <= 1'b1;
                    end
                end
                used[held] <= 1'b1;
                card_count <= card_count + 4'd1;
                sum        <= sum_next;
                soft_aces  <= aces_next;
                deal_ack   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: the driver queues the expected card for
// each deal, the monitor pops and compares on every deal_ack.
module tb_card_dealer;

    localparam int MAXC = 9;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            new_game = 1'b0;
    logic            deal_req = 1'b0;
    logic            force_en = 1'b0;
    logic [5:0]      force_code = '0;
    logic            deal_ack;
    logic [MAXC*6-1:0] slot_code;
    logic [MAXC-1:0] slot_valid;
    logic [3:0]      card_count;
    logic [4:0]      hand_value;
    logic            busy, hand_full, bust;

    card_dealer #(.MAX_CARDS(MAXC), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .deal_req(deal_req),
        .force_en(force_en), .force_code(force_code), .deal_ack(deal_ack),
        .slot_code(slot_code), .slot_valid(slot_valid), .card_count(card_count),
        .hand_value(hand_value), .busy(busy), .hand_full(hand_full), .bust(bust)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rnd;
        logic [5:0] code;
        logic [3:0] cnt;
        logic [4:0] val;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // soak-mode reference hand
    logic [63:0] seen;
    int          m_count, m_sum, m_aces;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic int cval(input logic [3:0] r);
        if (r == 4'd0) return 11;
        if (r >= 4'd10) return 10;
        return int'(r) + 1;
    endfunction

    // Monitor: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && deal_ack) begin
            if (q.size() == 0) begin
                check("unexpected_ack", 64'd1, 64'd0);
            end else begin
                exp_t e;
                logic [5:0] got;
                int idx;
                e = q.pop_front();
                idx = (card_count == 4'd0) ? 0 : int'(card_count) - 1;
                got = slot_code[idx*6 +: 6];
                if (!e.rnd) begin
                    check("ack_code",  64'(got), 64'(e.code));
                    check("ack_count", 64'(card_count), 64'(e.cnt));
                    check("ack_value", 64'(hand_value), 64'(e.val));
                end else begin
                    check("soak_rank_ok", 64'(got[3:0] <= 4'd12), 64'd1);
                    check("soak_dup", 64'(seen[got]), 64'd0);
                    seen[got] = 1'b1;
                    m_count++;
                    m_sum += cval(got[3:0]);
                    if (got[3:0] == 4'd0) m_aces++;
                    if (m_sum > 21 && m_aces > 0) begin
                        m_sum -= 10;
                        m_aces--;
                    end
                    check("soak_count", 64'(card_count), 64'(m_count));
                    check("soak_value", 64'(hand_value), 64'(m_sum));
                end
            end
        end
    end

    task automatic wait_ack(input string nm);
        int n;
        n = 0;
        while (n < 500) begin
            @(posedge clk); #1;
            if (deal_ack) break;
            n++;
        end
        if (!deal_ack) check({nm, "_timeout"}, 64'd0, 64'd1);
        deal_req = 1'b0;
    endtask

    task automatic deal(input logic [5:0] code, input logic [3:0] cnt, input logic [4:0] val);
        exp_t e;
        e.rnd = 1'b0; e.code = code; e.cnt = cnt; e.val = val;
        q.push_back(e);
        force_en = 1'b1;
        force_code = code;
        deal_req = 1'b1;
        wait_ack("deal");
    endtask

    task automatic pulse_ng();
        new_game = 1'b1;
        @(posedge clk); #1;
        new_game = 1'b0;
    endtask

    logic [5:0] full_codes [9] = '{6'h00, 6'h10, 6'h20, 6'h30, 6'h01, 6'h11, 6'h21, 6'h31, 6'h02};
    logic [4:0] full_vals  [9] = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd16, 5'd18, 5'd20, 5'd12, 5'd15};

    initial begin
        exp_t e;
        int total;
        seen = '0; m_count = 0; m_sum = 0; m_aces = 0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack",   64'(deal_ack), 64'd0);
        check("rst_slots", 64'(slot_code), 64'd0);
        check("rst_valid", 64'(slot_valid), 64'd0);
        check("rst_count", 64'(card_count), 64'd0);
        check("rst_flags", 64'({hand_value, busy, hand_full, bust}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // two-cycle latency from the IDLE sample
        e.rnd = 1'b0; e.code = 6'h05; e.cnt = 4'd1; e.val = 5'd6;
        q.push_back(e);
        force_en = 1'b1; force_code = 6'h05; deal_req = 1'b1;
        @(posedge clk); #1;
        check("lat_busy1", 64'({busy, deal_ack}), 64'b10);
        @(posedge clk); #1;
        check("lat_busy2", 64'({busy, deal_ack}), 64'b10);
        @(posedge clk); #1;
        check("lat_ack",   64'(deal_ack), 64'd1);
        check("lat_count", 64'(card_count), 64'd1);
        check("lat_valid", 64'(slot_valid), 64'h001);
        deal_req = 1'b0;
        @(posedge clk); #1;

        // reset in the middle of a draw
        force_code = 6'h0D; deal_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #2;
        check("mid_rst", 64'({card_count, slot_valid, busy, deal_ack}), 64'd0);
        deal_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // soft ace handling
        deal(6'h00, 4'd1, 5'd11);
        deal(6'h15, 4'd2, 5'd17);
        deal(6'h29, 4'd3, 5'd17);
        check("soft_bust", 64'(bust), 64'd0);

        // duplicate retry
        pulse_ng();
        deal(6'h07, 4'd1, 5'd8);
        e.rnd = 1'b0; e.code = 6'h08; e.cnt = 4'd2; e.val = 5'd17;
        q.push_back(e);
        force_code = 6'h07; deal_req = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("dup_wait", 64'({busy, deal_ack}), 64'b10);
        end
        force_code = 6'h08;
        wait_ack("dup");
        check("dup_slot1", 64'(slot_code[11:6]), 64'h08);

        // invalid rank held off until a valid code appears
        e.rnd = 1'b0; e.code = 6'h02; e.cnt = 4'd3; e.val = 5'd20;
        q.push_back(e);
        force_code = 6'h0D; deal_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("inv_wait", 64'({busy, deal_ack}), 64'b10);
        end
        force_code = 6'h02;
        wait_ack("inv");

        // full hand
        pulse_ng();
        for (int i = 0; i < 9; i++) deal(full_codes[i], 4'(i + 1), full_vals[i]);
        check("full_flag",  64'(hand_full), 64'd1);
        check("full_valid", 64'(slot_valid), 64'h1FF);
        force_code = 6'h03; deal_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("full_idle", 64'({busy, deal_ack}), 64'b00);
        end
        deal_req = 1'b0;

        // new_game landing on COMMIT
        pulse_ng();
        force_code = 6'h04; deal_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ngc_busy", 64'(busy), 64'd1);
        new_game = 1'b1; deal_req = 1'b0;
        @(posedge clk); #1;
        new_game = 1'b0;
        check("ngc_clear", 64'({card_count, slot_valid, deal_ack, busy}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        deal(6'h04, 4'd1, 5'd5);

        // random soak: no duplicates within a hand
        force_en = 1'b0;
        total = 0;
        while (total < 100) begin
            pulse_ng();
            seen = '0; m_count = 0; m_sum = 0; m_aces = 0;
            while (total < 100 && m_count < MAXC && m_sum <= 21) begin
                e.rnd = 1'b1; e.code = '0; e.cnt = '0; e.val = '0;
                q.push_back(e);
                deal_req = 1'b1;
                wait_ack("soak");
                @(negedge clk); #1;
                total++;
            end
        end

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
